score_event_scheduler: RTL and testbench

//  Collects score events (hit, bonus, cheat) from NUM_SRC requesters and serialises them

---
 rtl/score_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/score_event_scheduler.sv | 169 ++++++++++++++++
 tb/tb_score_event_scheduler.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types for the score event scheduler: FSM states and issued event kinds.
package score_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_FROZEN} sched_state_t;
   typedef enum logic [1:0] {EV_NONE, EV_HIT, EV_BONUS, EV_CHEAT} score_ev_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic             valid
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(N)) sum = sum - (PTR_W+1)'(N);
         idx = sum[PTR_W-1:0];
         if (!valid && req[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/score_event_scheduler.sv
// Serialises hit/bonus/cheat requests from several sources into paced single-cycle
// pulses for the BCD score counter; freezes on game over or score terminal count.
//
//   state    | meaning
//   S_IDLE   | nothing in flight, waiting for a pending event
//   S_ISSUE  | driving exactly one pulse from the latched grant
//   S_GAP    | forced idle spacing after a pulse
//   S_FROZEN | game finished, everything cleared and ignored until reset
module score_event_scheduler
   import score_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int PEND_W     = 3,
   parameter int GAP_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] srcHit,
   input  logic [NUM_SRC-1:0] srcBonus,
   input  logic               cheatReq,
   input  logic               gameOver,
   input  logic               scoreTc,
   output logic               hit,
   output logic               bonus,
   output logic               scoreCheat,
   output logic               busy,
   output logic               dropped
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

   sched_state_t       state, state_nxt;
   score_ev_t          ev_q, ev_sel;
   logic [PEND_W-1:0]  hit_pend   [NUM_SRC];
   logic [PEND_W-1:0]  bonus_pend [NUM_SRC];
   logic               cheat_pend, cheat_q;
   logic [PTR_W-1:0]   rr_ptr, rr_next, src_q, grant_idx;
   logic [GAP_W-1:0]   gap_cnt;
   logic [NUM_SRC-1:0] src_req, grant;
   logic [NUM_SRC-1:0] hit_dec, bonus_dec, hit_drop, bonus_drop;
   logic               grant_valid, any_pending, freeze, load_grant, issuing;
   logic               cheat_rise, cheat_dec, cheat_drop;

   function automatic logic [PEND_W-1:0] pend_next(input logic [PEND_W-1:0] cnt,
                                                   input logic inc, input logic dec);
      logic [PEND_W-1:0] r;
      r = cnt;
      if (inc && !dec && cnt != PEND_MAX) r = cnt + PEND_W'(1);
      else if (!inc && dec)               r = cnt - PEND_W'(1);
      return r;
   endfunction

   rr_arbiter #(.N(NUM_SRC), .PTR_W(PTR_W)) u_rr_arbiter (
      .req   (src_req),
      .ptr   (rr_ptr),
      .grant (grant),
      .valid (grant_valid)
   );

   assign issuing     = (state == S_ISSUE);
   assign any_pending = cheat_pend | grant_valid;
   assign freeze      = gameOver | scoreTc | (state == S_FROZEN);
   assign cheat_rise  = cheatReq & ~cheat_q;
   assign cheat_dec   = issuing && (ev_q == EV_CHEAT);
   assign cheat_drop  = cheat_rise & cheat_pend & ~cheat_dec;
   assign rr_next     = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);

   always_comb begin
      src_req    = '0;
      hit_dec    = '0;
      bonus_dec  = '0;
      hit_drop   = '0;
      bonus_drop = '0;
      grant_idx  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_req[i]    = (hit_pend[i] != '0) || (bonus_pend[i] != '0);
         hit_dec[i]    = issuing && (ev_q == EV_HIT)   && (src_q == PTR_W'(i));
         bonus_dec[i]  = issuing && (ev_q == EV_BONUS) && (src_q == PTR_W'(i));
         hit_drop[i]   = srcHit[i]   && !hit_dec[i]   && (hit_pend[i] == PEND_MAX);
         bonus_drop[i] = srcBonus[i] && !bonus_dec[i] && (bonus_pend[i] == PEND_MAX);
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   // Cheat always wins the slot; within a source, bonus goes before hit.
   always_comb begin
      ev_sel = EV_HIT;
      if (cheat_pend)                     ev_sel = EV_CHEAT;
      else if (bonus_pend[grant_idx] != '0) ev_sel = EV_BONUS;
   end

   always_comb begin
      state_nxt  = state;
      load_grant = 1'b0;
      if (gameOver || scoreTc) begin
         state_nxt = S_FROZEN;
      end else begin
         case (state)
            S_IDLE: begin
               if (any_pending) begin
                  state_nxt  = S_ISSUE;
                  load_grant = 1'b1;
               end
            end
            S_ISSUE: state_nxt = S_GAP;
            S_GAP: begin
               if (gap_cnt == '0) begin
                  if (any_pending) begin
                     state_nxt  = S_ISSUE;
                     load_grant = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
            end
            S_FROZEN: state_nxt = S_FROZEN;
            default:  state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         ev_q    <= EV_NONE;
         src_q   <= '0;
         rr_ptr  <= '0;
         gap_cnt <= '0;
         cheat_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         cheat_q <= cheatReq;
         if (load_grant) begin
            ev_q  <= ev_sel;
            src_q <= grant_idx;
            if (ev_sel != EV_CHEAT) rr_ptr <= rr_next;
         end
         if (issuing)                           gap_cnt <= GAP_LOAD;
         else if (state == S_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || freeze) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            hit_pend[i]   <= '0;
            bonus_pend[i] <= '0;
         end
         cheat_pend <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            hit_pend[i]   <= pend_next(hit_pend[i],   srcHit[i],   hit_dec[i]);
            bonus_pend[i] <= pend_next(bonus_pend[i], srcBonus[i], bonus_dec[i]);
         end
         cheat_pend <= cheat_rise | (cheat_pend & ~cheat_dec);
         dropped    <= (|hit_drop) | (|bonus_drop) | cheat_drop;
      end
   end

   assign hit        = issuing && (ev_q == EV_HIT);
   assign bonus      = issuing && (ev_q == EV_BONUS);
   assign scoreCheat = issuing && (ev_q == EV_CHEAT);
   assign busy       = issuing || (state == S_GAP) || any_pending;

endmodule

// File: tb/tb_score_event_scheduler.sv
// Bench for score_event_scheduler: directed scenarios then random traffic, all checked
// cycle by cycle against a slot/queue-level reference model.
module tb_score_event_scheduler;

   localparam int N    = 4;
   localparam int PW   = 3;
   localparam int G    = 1;
   localparam int PMAX = (1 << PW) - 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] srcHit, srcBonus;
   logic         cheatReq, gameOver, scoreTc;
   logic         hit, bonus, scoreCheat, busy, dropped;

   score_event_scheduler #(.NUM_SRC(N), .PEND_W(PW), .GAP_CYCLES(G)) dut (
      .clk        (clk),
      .reset      (reset),
      .srcHit     (srcHit),
      .srcBonus   (srcBonus),
      .cheatReq   (cheatReq),
      .gameOver   (gameOver),
      .scoreTc    (scoreTc),
      .hit        (hit),
      .bonus      (bonus),
      .scoreCheat (scoreCheat),
      .busy       (busy),
      .dropped    (dropped)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // reference model: queued counts, slot timing by cycle arithmetic
   int hp [N];
   int bp [N];
   int cp, rr, last_pulse, plan_ev, plan_src;
   bit frozen, prev_ch, m_drop, plan_v;

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0b expected %0b", tag, cyc, got, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         hp[i] = 0;
         bp[i] = 0;
      end
      cp = 0; rr = 0; last_pulse = -1000; plan_v = 0; plan_ev = 0; plan_src = 0;
      frozen = 0; prev_ch = 0; m_drop = 0;
   endtask

   task automatic step(input logic [N-1:0] h, input logic [N-1:0] b, input logic ch,
                       input logic go, input logic tc, input logic rst);
      bit anyp;
      int now_ev, now_src, v, j;
      @(negedge clk);
      anyp = (cp != 0);
      for (int i = 0; i < N; i++) if (hp[i] != 0 || bp[i] != 0) anyp = 1;
      check("hit",        hit,        plan_v && plan_ev == 1);
      check("bonus",      bonus,      plan_v && plan_ev == 2);
      check("scoreCheat", scoreCheat, plan_v && plan_ev == 3);
      check("busy", busy, !frozen && (plan_v || anyp ||
                          (cyc - last_pulse >= 1 && cyc - last_pulse <= G)));
      check("dropped", dropped, m_drop);

      srcHit = h; srcBonus = b; cheatReq = ch; gameOver = go; scoreTc = tc; reset = rst;

      if (rst) begin
         model_reset();
      end else begin
         now_ev = 0; now_src = 0;
         if (plan_v) begin
            now_ev = plan_ev; now_src = plan_src; last_pulse = cyc; plan_v = 0;
         end
         if (!frozen && !go && !tc && anyp && (cyc - last_pulse >= G)) begin
            plan_v = 1;
            if (cp != 0) begin
               plan_ev = 3;
            end else begin
               for (int k = N - 1; k >= 0; k--) begin
                  j = (rr + k) % N;
                  if (hp[j] != 0 || bp[j] != 0) plan_src = j;
               end
               plan_ev = (bp[plan_src] != 0) ? 2 : 1;
               rr = (plan_src + 1) % N;
            end
         end
         if (frozen || go || tc) begin
            for (int i = 0; i < N; i++) begin
               hp[i] = 0;
               bp[i] = 0;
            end
            cp = 0; m_drop = 0; frozen = 1;
         end else begin
            m_drop = 0;
            for (int i = 0; i < N; i++) begin
               v = hp[i] + int'(h[i]) - ((now_ev == 1 && now_src == i) ? 1 : 0);
               if (v > PMAX) begin v = PMAX; m_drop = 1; end
               hp[i] = v;
               v = bp[i] + int'(b[i]) - ((now_ev == 2 && now_src == i) ? 1 : 0);
               if (v > PMAX) begin v = PMAX; m_drop = 1; end
               bp[i] = v;
            end
            v = cp + ((ch && !prev_ch) ? 1 : 0) - ((now_ev == 3) ? 1 : 0);
            if (v > 1) begin v = 1; m_drop = 1; end
            cp = v;
         end
         prev_ch = ch;
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] rh, rb;
      logic rch, rgo, rtc, rrst;
      int frozen_for;
      reset = 1'b1; srcHit = '0; srcBonus = '0; cheatReq = 1'b0; gameOver = 1'b0; scoreTc = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // single hit from source 2: pulse two cycles after the request
      idle(4);
      step(4'b0100, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(5);
      // all four sources at once: paced, round-robin
      step(4'b1111, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(10);
      // bonus and hit from the same source: bonus first
      step(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(6);
      // held hit with a cheat edge inside, long enough to saturate
      for (int k = 0; k < 20; k++) step(4'b0001, '0, k >= 3 && k < 12, 1'b0, 1'b0, 1'b0);
      idle(20);
      // pending work then game over, requests ignored until reset
      step(4'b0111, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      step('0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) step(4'b1111, 4'b1010, k[0], 1'b0, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(4);
      // reset in the middle of a gap with work still pending
      step(4'b0011, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(3);
      step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(6);
      // scoreTc freeze
      step(4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2);
      step(4'b1111, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      step('0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

      frozen_for = 0;
      for (int c = 0; c < 4000; c++) begin
         rh   = N'($urandom & $urandom);
         rb   = N'($urandom & $urandom & $urandom);
         rch  = ($urandom_range(0, 9) == 0) ? ~cheatReq : cheatReq;
         rgo  = ($urandom_range(0, 499) == 0);
         rtc  = ($urandom_range(0, 499) == 0);
         rrst = ($urandom_range(0, 399) == 0) || (frozen_for > 8);
         frozen_for = frozen ? frozen_for + 1 : 0;
         if (c % 600 < 60) rh = '1;
         step(rh, rb, rch, rgo, rtc, rrst);
      end
      idle(8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
